// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types and geometry for the direct-mapped branch prediction table
// Contents: table geometry (PC_W, INDEX_W, TAG_W and PC field bounds), the 2-bit
// counter encoding, the per-entry record and its reset value.
package bpred_pkg;
    localparam int PC_W    = 32;
    localparam int INDEX_W = 8;
    localparam int TAG_W   = 4;
    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int IDX_LO  = 2;
    localparam int IDX_HI  = INDEX_W + 1;
    localparam int TAG_LO  = INDEX_W + 2;
    localparam int TAG_HI  = INDEX_W + TAG_W + 1;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt2_t;
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        cnt2_t            cnt;
    } bpred_entry_t;
    localparam bpred_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
endpackage

// File: rtl/bpred_if.sv
// bpred_if: fetch-read and execute-update bus of the branch prediction table
// master (fetch/execute side): drives pc_i, flush_i, upd_en_i, upd_pc_i, upd_taken_i,
//   upd_target_i; receives tag_o, flag_br_o, taken_o, target_o.
// slave (table side): the reverse directions.
interface bpred_if;
    import bpred_pkg::*;
    logic [PC_W-1:0]  pc_i;
    logic [TAG_W-1:0] tag_o;
    logic             flag_br_o;
    logic             taken_o;
    logic [PC_W-1:0]  target_o;
    logic             flush_i;
    logic             upd_en_i;
    logic [PC_W-1:0]  upd_pc_i;
    logic             upd_taken_i;
    logic [PC_W-1:0]  upd_target_i;
    modport master (
        output pc_i, flush_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  tag_o, flag_br_o, taken_o, target_o
    );
    modport slave (
        input  pc_i, flush_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        output tag_o, flag_br_o, taken_o, target_o
    );
endinterface

// File: rtl/sat_cnt2.sv
// sat_cnt2: next state of a 2-bit saturating branch counter
// Ports: cnt_i current state, taken_i resolved outcome, cnt_o next state.
module sat_cnt2
    import bpred_pkg::*;
(
    input  cnt2_t cnt_i,
    input  logic  taken_i,
    output cnt2_t cnt_o
);
    assign cnt_o = taken_i ? ((cnt_i == ST)  ? ST  : cnt2_t'(cnt_i + 2'd1))
                           : ((cnt_i == SNT) ? SNT : cnt2_t'(cnt_i - 2'd1));
endmodule

// File: rtl/bpred_table.sv
// bpred_table: direct-mapped flop-based branch prediction table with 2-bit counters
// Ports: clk_i clock; rst_i async active-high reset; bus (bpred_if.slave) carrying the
// combinational fetch read (pc_i -> tag_o/flag_br_o/taken_o/target_o) and the
// execute-stage update/flush inputs.
// Optional: define BPRED_BYPASS_EN to forward a same-index update onto the read outputs.
module bpred_table
    import bpred_pkg::*;
(
    input logic    clk_i,
    input logic    rst_i,
    bpred_if.slave bus
);
    bpred_entry_t       r_tbl [ENTRIES];
    logic [INDEX_W-1:0] w_rd_idx;
    logic [INDEX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    bpred_entry_t       w_cur;
    bpred_entry_t       w_new;
    bpred_entry_t       w_rd;
    bpred_entry_t       w_out;
    cnt2_t              w_cnt_nxt;
    logic               w_hit;
    logic               w_wr;
    logic               w_kill;
    logic               w_unused;

    assign w_rd_idx  = bus.pc_i[IDX_HI:IDX_LO];
    assign w_upd_idx = bus.upd_pc_i[IDX_HI:IDX_LO];
    assign w_upd_tag = bus.upd_pc_i[TAG_HI:TAG_LO];
    assign w_cur     = r_tbl[w_upd_idx];
    assign w_rd      = r_tbl[w_rd_idx];
    assign w_hit     = w_cur.valid && (w_cur.tag == w_upd_tag);
    // A not-taken miss leaves the entry alone; flush suppresses any update.
    assign w_wr      = bus.upd_en_i && !bus.flush_i && (w_hit || bus.upd_taken_i);

    sat_cnt2 u_cnt (
        .cnt_i   (w_cur.cnt),
        .taken_i (bus.upd_taken_i),
        .cnt_o   (w_cnt_nxt)
    );

    assign w_new = w_hit
        ? '{valid: 1'b1, tag: w_cur.tag,
            target: bus.upd_taken_i ? bus.upd_target_i : w_cur.target, cnt: w_cnt_nxt}
        : '{valid: 1'b1, tag: w_upd_tag, target: bus.upd_target_i, cnt: WT};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= ENTRY_RST;
        end else if (bus.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) r_tbl[i].valid <= 1'b0;
        end else if (w_wr) begin
            r_tbl[w_upd_idx] <= w_new;
        end
    end

`ifdef BPRED_BYPASS_EN
    logic w_fwd;
    assign w_fwd  = bus.upd_en_i && (w_rd_idx == w_upd_idx);
    assign w_out  = (w_fwd && w_wr) ? w_new : w_rd;
    assign w_kill = w_fwd && bus.flush_i;
`else
    assign w_out  = w_rd;
    assign w_kill = 1'b0;
`endif

    assign bus.tag_o     = w_out.tag;
    assign bus.flag_br_o = w_out.valid && !w_kill;
    assign bus.taken_o   = w_out.cnt[1];
    assign bus.target_o  = w_out.target;

    assign w_unused = ^{bus.pc_i[PC_W-1:IDX_HI+1], bus.pc_i[1:0],
                        bus.upd_pc_i[PC_W-1:TAG_HI+1], bus.upd_pc_i[1:0], w_out.cnt[0]};
endmodule

// File: tb/tb_bpred_table.sv
// tb_bpred_table: table-driven and randomized self-checking bench for bpred_table
module tb_bpred_table;
    logic clk = 1'b0;
    logic rst = 1'b0;
    bpred_if bus ();
    bpred_table dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct { bit v; bit [3:0] tag; bit [31:0] tgt; int cnt; } ment_t;
    typedef struct {
        bit [31:0] pc; bit fl; bit en; bit [31:0] upc; bit t; bit [31:0] utgt;
        bit [3:0] etag; bit eflag; bit etaken; bit [31:0] etgt;
    } vec_t;

    ment_t m [256];
    vec_t  tbl [24];
    int errors = 0;
    int checks = 0;

    localparam bit [31:0] A = 32'h2404, B = 32'h0404, C = 32'h0C04, Z = 32'h0, D = 32'h0008;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(bit [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    function automatic bit [3:0] tag_of(bit [31:0] pc);
        return 4'((pc >> 10) % 16);
    endfunction

    function automatic ment_t m_next(ment_t e, bit [31:0] upc, bit t, bit [31:0] tgt);
        ment_t n = e;
        if (e.v && e.tag == tag_of(upc)) begin
            n.cnt = t ? ((e.cnt + 1 > 3) ? 3 : e.cnt + 1) : ((e.cnt - 1 < 0) ? 0 : e.cnt - 1);
            if (t) n.tgt = tgt;
        end else if (t) begin
            n.v = 1; n.tag = tag_of(upc); n.tgt = tgt; n.cnt = 2;
        end
        return n;
    endfunction

    task automatic m_reset();
        foreach (m[i]) m[i] = '{v: 0, tag: 0, tgt: 0, cnt: 1};
    endtask

    function automatic vec_t mk(bit [31:0] pc, bit fl, bit en, bit [31:0] upc, bit t, bit [31:0] utgt,
                                bit [3:0] etag, bit eflag, bit etaken, bit [31:0] etgt);
        vec_t v;
        v.pc = pc; v.fl = fl; v.en = en; v.upc = upc; v.t = t; v.utgt = utgt;
        v.etag = etag; v.eflag = eflag; v.etaken = etaken; v.etgt = etgt;
        return v;
    endfunction

    function automatic vec_t with_model(vec_t v);
        ment_t e = m[idx_of(v.pc)];
`ifdef BPRED_BYPASS_EN
        if (v.en && idx_of(v.pc) == idx_of(v.upc)) begin
            if (v.fl) e.v = 0;
            else e = m_next(e, v.upc, v.t, v.utgt);
        end
`endif
        v.etag = e.tag; v.eflag = e.v; v.etaken = (e.cnt >= 2); v.etgt = e.tgt;
        return v;
    endfunction

    task automatic cyc(input vec_t v, input string name);
        @(negedge clk);
        bus.pc_i = v.pc; bus.flush_i = v.fl; bus.upd_en_i = v.en;
        bus.upd_pc_i = v.upc; bus.upd_taken_i = v.t; bus.upd_target_i = v.utgt;
        #1;
        chk({name, " tag"},    32'(bus.tag_o),     32'(v.etag));
        chk({name, " flag"},   32'(bus.flag_br_o), 32'(v.eflag));
        chk({name, " taken"},  32'(bus.taken_o),   32'(v.etaken));
        chk({name, " target"}, bus.target_o,       v.etgt);
        @(posedge clk);
        if (v.fl) foreach (m[i]) m[i].v = 0;
        else if (v.en) m[idx_of(v.upc)] = m_next(m[idx_of(v.upc)], v.upc, v.t, v.utgt);
    endtask

    task automatic chk_zero(input string name);
        chk({name, " tag"},    32'(bus.tag_o),     32'h0);
        chk({name, " flag"},   32'(bus.flag_br_o), 32'h0);
        chk({name, " taken"},  32'(bus.taken_o),   32'h0);
        chk({name, " target"}, bus.target_o,       32'h0);
    endtask

    initial begin
        bus.pc_i = $urandom; bus.flush_i = 0; bus.upd_en_i = 0;
        bus.upd_pc_i = 0; bus.upd_taken_i = 0; bus.upd_target_i = 0;
        #1 rst = 1'b1;
        #2 chk_zero("in_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #2 chk_zero("after_reset");
        m_reset();

        tbl[0]  = mk(Z, 0, 1, A, 1, 32'h100,  4'h0, 0, 0, 32'h0);
        tbl[1]  = mk(A, 0, 0, Z, 0, 32'h0,    4'h9, 1, 1, 32'h100);
        tbl[2]  = mk(Z, 0, 1, A, 0, 32'hdead, 4'h0, 0, 0, 32'h0);
        tbl[3]  = mk(A, 0, 0, Z, 0, 32'h0,    4'h9, 1, 0, 32'h100);
        tbl[4]  = mk(Z, 0, 1, A, 0, 32'hbeef, 4'h0, 0, 0, 32'h0);
        tbl[5]  = mk(Z, 0, 1, A, 0, 32'hbeef, 4'h0, 0, 0, 32'h0);
        tbl[6]  = mk(A, 0, 0, Z, 0, 32'h0,    4'h9, 1, 0, 32'h100);
        tbl[7]  = mk(Z, 0, 1, A, 1, 32'h140,  4'h0, 0, 0, 32'h0);
        tbl[8]  = mk(A, 0, 0, Z, 0, 32'h0,    4'h9, 1, 0, 32'h140);
        tbl[9]  = mk(Z, 0, 1, A, 1, 32'h140,  4'h0, 0, 0, 32'h0);
        tbl[10] = mk(A, 0, 0, Z, 0, 32'h0,    4'h9, 1, 1, 32'h140);
        tbl[11] = mk(Z, 0, 1, A, 1, 32'h140,  4'h0, 0, 0, 32'h0);
        tbl[12] = mk(Z, 0, 1, A, 1, 32'h140,  4'h0, 0, 0, 32'h0);
        tbl[13] = mk(Z, 0, 1, A, 0, 32'h0,    4'h0, 0, 0, 32'h0);
        tbl[14] = mk(A, 0, 0, Z, 0, 32'h0,    4'h9, 1, 1, 32'h140);
        tbl[15] = mk(Z, 0, 1, B, 1, 32'h200,  4'h0, 0, 0, 32'h0);
        tbl[16] = mk(B, 0, 0, Z, 0, 32'h0,    4'h1, 1, 1, 32'h200);
        tbl[17] = mk(Z, 0, 1, C, 0, 32'h999,  4'h0, 0, 0, 32'h0);
        tbl[18] = mk(A, 0, 0, Z, 0, 32'h0,    4'h1, 1, 1, 32'h200);
        tbl[19] = mk(Z, 1, 1, D, 1, 32'h300,  4'h0, 0, 0, 32'h0);
        tbl[20] = mk(B, 0, 0, Z, 0, 32'h0,    4'h1, 0, 1, 32'h200);
        tbl[21] = mk(D, 0, 0, Z, 0, 32'h0,    4'h0, 0, 0, 32'h0);
`ifdef BPRED_BYPASS_EN
        tbl[22] = mk(B, 0, 1, B, 1, 32'h240,  4'h1, 1, 1, 32'h240);
`else
        tbl[22] = mk(B, 0, 1, B, 1, 32'h240,  4'h1, 0, 1, 32'h200);
`endif
        tbl[23] = mk(B, 0, 0, Z, 0, 32'h0,    4'h1, 1, 1, 32'h240);
        for (int i = 0; i < 24; i++) cyc(tbl[i], $sformatf("row%0d", i));

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v.pc  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2);
            v.upc = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2);
            v.fl  = ($urandom_range(0, 19) == 0);
            v.en  = 1'($urandom_range(0, 1));
            v.t   = 1'($urandom_range(0, 1));
            v.utgt = $urandom;
            cyc(with_model(v), $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        bus.pc_i = B; bus.flush_i = 0; bus.upd_en_i = 1;
        bus.upd_pc_i = A; bus.upd_taken_i = 1; bus.upd_target_i = 32'h555;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        bus.upd_en_i = 0;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            vec_t v = mk(32'(i) << 2, 0, 0, Z, 0, 32'h0, 4'h0, 0, 0, 32'h0);
            cyc(with_model(v), $sformatf("post_rst%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
